// File: rtl/iop_queue_pkg.sv
// Shared definitions for the decode-to-station iop queue: station status
// encodings, the packed entry layout and helpers to pack/unpack an entry.
package iop_queue_pkg;

  // Initial station status carried with each iop. COMPLETE is all-zero so a
  // masked (empty) head reads as an idle station slot.
  typedef enum logic [2:0] {
    ST_COMPLETE = 3'b000,
    ST_WAIT_1   = 3'b001,
    ST_WAIT_2   = 3'b010,
    ST_WAIT_3   = 3'b011,
    ST_LOAD_0   = 3'b100,
    ST_LOAD_1   = 3'b101,
    ST_ALU      = 3'b110,
    ST_STORE    = 3'b111
  } st_status_e;

  // Field widths of one queued entry.
  localparam int IOP_W   = 32;
  localparam int INIT_W  = 3;
  localparam int PC_W    = 16;
  localparam int K16_W   = 16;
  localparam int ENTRY_W = IOP_W + INIT_W + PC_W + K16_W;  // 67

  // Bit positions of each field inside the packed entry word.
  localparam int K16_LSB  = 0;
  localparam int PC_LSB   = K16_LSB + K16_W;    // 16
  localparam int INIT_LSB = PC_LSB + PC_W;      // 32
  localparam int IOP_LSB  = INIT_LSB + INIT_W;  // 35
  localparam int IOP_MSB  = IOP_LSB + IOP_W - 1; // 66

  // Unpacked view of one entry; member order matches the bit positions above.
  typedef struct packed {
    logic [IOP_W-1:0]  iop;
    logic [INIT_W-1:0] init;
    logic [PC_W-1:0]   pc;
    logic [K16_W-1:0]  k16;
  } iop_entry_t;

  // Build a packed entry word from its fields so they always travel together.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [IOP_W-1:0]  iop,
    input logic [INIT_W-1:0] init,
    input logic [PC_W-1:0]   pc,
    input logic [K16_W-1:0]  k16
  );
    iop_entry_t e;
    e.iop  = iop;
    e.init = init;
    e.pc   = pc;
    e.k16  = k16;
    return e;
  endfunction

  // Reinterpret a packed entry word as the structured view.
  function automatic iop_entry_t unpack_entry(input logic [ENTRY_W-1:0] w);
    return iop_entry_t'(w);
  endfunction

endpackage

// File: rtl/iop_queue_mem.sv
// DEPTH x W register array, one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset; validity is tracked by the
// owner through its occupancy count.
module iop_queue_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 67
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/iop_queue.sv
// Decoupling FIFO between the instruction decoder and the reservation station
// (producer side of the station's id_* interface), with flush and occupancy.
//
// Handshakes: a transfer happens in a cycle exactly when valid and ready are
// both high at the rising edge. Decoder side: valid=dec_valid, ready=dec_ready.
// Station side: valid=id_ack, ready=id_feed. Both dec_ready and id_ack are
// functions of registered state only, so neither has a combinational path from
// the opposite side's ready/valid or from flush. The decoder must hold its
// outputs while dec_ready is low.
module iop_queue
  import iop_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              dec_valid,
  input  logic [IOP_W-1:0]  dec_iop,
  input  logic [INIT_W-1:0] dec_iop_init,
  input  logic [PC_W-1:0]   dec_pc,
  input  logic [K16_W-1:0]  dec_k16,
  output logic              dec_ready,
  input  logic              flush,
  input  logic              id_feed,
  output logic              id_ack,
  output logic [IOP_W-1:0]  id_iop,
  output logic [INIT_W-1:0] id_iop_init,
  output logic [PC_W-1:0]   id_pc,
  output logic [K16_W-1:0]  id_k16,
  output logic [AW:0]       q_count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic               push;
  logic               pop;
  logic               mem_we;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  iop_entry_t         head;

  // Full and empty come from the count, never from pointer equality, since
  // the pointers are equal in both cases.
  assign dec_ready = (count_q != FULL_CNT);
  assign id_ack    = (count_q != '0);
  assign q_count   = count_q;

  assign push = dec_valid & dec_ready;
  assign pop  = id_ack & id_feed;

  // Flush drops a concurrent push, so the array is not written either.
  assign mem_we   = push & ~flush;
  assign wr_entry = pack_entry(dec_iop, dec_iop_init, dec_pc, dec_k16);

  iop_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Next-state for pointers and count; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head fields are masked to zero when empty so unwritten storage never
  // leaks out and the status reads as COMPLETE.
  always_comb begin
    head        = unpack_entry(rd_entry);
    id_iop      = '0;
    id_iop_init = ST_COMPLETE;
    id_pc       = '0;
    id_k16      = '0;
    if (id_ack) begin
      id_iop      = head.iop;
      id_iop_init = head.init;
      id_pc       = head.pc;
      id_k16      = head.k16;
    end
  end

endmodule

// File: tb/tb_iop_queue.sv
// Directed bench for iop_queue: reset, single transfer, full/drain ordering,
// full-with-pop, wrap under concurrent push/pop, flush, and async reset.
module tb_iop_queue;

  logic        clk;
  logic        a_rst;
  logic        dec_valid;
  logic [31:0] dec_iop;
  logic [2:0]  dec_iop_init;
  logic [15:0] dec_pc;
  logic [15:0] dec_k16;
  logic        dec_ready;
  logic        flush;
  logic        id_feed;
  logic        id_ack;
  logic [31:0] id_iop;
  logic [2:0]  id_iop_init;
  logic [15:0] id_pc;
  logic [15:0] id_k16;
  logic [2:0]  q_count;

  int checks;
  int errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;

  iop_queue #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .dec_valid    (dec_valid),
    .dec_iop      (dec_iop),
    .dec_iop_init (dec_iop_init),
    .dec_pc       (dec_pc),
    .dec_k16      (dec_k16),
    .dec_ready    (dec_ready),
    .flush        (flush),
    .id_feed      (id_feed),
    .id_ack       (id_ack),
    .id_iop       (id_iop),
    .id_iop_init  (id_iop_init),
    .id_pc        (id_pc),
    .id_k16       (id_k16),
    .q_count      (q_count)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Occupancy invariant watched every cycle.
  always @(negedge clk) begin
    checks++;
    if (q_count > 3'd4) begin
      errors++;
      $display("FAIL inv_count got %0d exp <= 4", q_count);
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [15:0] pc);
    dec_valid    = 1'b1;
    dec_iop      = {16'hA5A5, pc};
    dec_iop_init = pc[2:0];
    dec_pc       = pc;
    dec_k16      = ~pc;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; dec_valid = 1'b0; dec_iop = '0; dec_iop_init = '0;
    dec_pc = '0; dec_k16 = '0; flush = 1'b0; id_feed = 1'b0;
    #2;
    checks++; if (id_ack !== 1'b0) begin errors++; $display("FAIL rst_pre_ack got %b exp 0", id_ack); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_ready got %b exp 1", dec_ready); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_pre_count got %0d exp 0", q_count); end
    checks++; if (id_iop_init !== 3'b000 || id_iop !== 32'h0 || id_pc !== 16'h0 || id_k16 !== 16'h0) begin
      errors++; $display("FAIL rst_pre_fields got %h %b %h %h exp 0", id_iop, id_iop_init, id_pc, id_k16);
    end
    step(); step();
    a_rst = 1'b0;
    step();
    checks++; if (id_ack !== 1'b0 || dec_ready !== 1'b1 || q_count !== 3'd0 || id_iop_init !== 3'b000) begin
      errors++; $display("FAIL rst_post got ack=%b rdy=%b cnt=%0d init=%b exp 0 1 0 000", id_ack, dec_ready, q_count, id_iop_init);
    end
  endtask

  task automatic test_single();
    dec_valid = 1'b1; dec_iop = 32'h0000_0420; dec_iop_init = 3'b110;
    dec_pc = 16'h1000; dec_k16 = 16'h0042; id_feed = 1'b1;
    step();
    dec_valid = 1'b0;
    checks++; if (id_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", id_ack); end
    checks++; if (id_iop !== 32'h0000_0420) begin errors++; $display("FAIL single_iop got %h exp 00000420", id_iop); end
    checks++; if (id_iop_init !== 3'b110) begin errors++; $display("FAIL single_init got %b exp 110", id_iop_init); end
    checks++; if (id_pc !== 16'h1000) begin errors++; $display("FAIL single_pc got %h exp 1000", id_pc); end
    checks++; if (id_k16 !== 16'h0042) begin errors++; $display("FAIL single_k16 got %h exp 0042", id_k16); end
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", q_count); end
    step();
    id_feed = 1'b0;
    checks++; if (id_ack !== 1'b0 || q_count !== 3'd0) begin
      errors++; $display("FAIL single_empty got ack=%b cnt=%0d exp 0 0", id_ack, q_count);
    end
    checks++; if (id_pc !== 16'h0 || id_iop_init !== 3'b000) begin
      errors++; $display("FAIL single_mask got pc=%h init=%b exp 0000 000", id_pc, id_iop_init);
    end
  endtask

  task automatic test_full_drain();
    id_feed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(16'h0010 + 16'(i));
      exp_q.push_back(16'h0010 + 16'(i));
      step();
    end
    checks++; if (q_count !== 3'd4 || dec_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b exp 4 0", q_count, dec_ready);
    end
    drive_push(16'h0014);
    step();
    dec_valid = 1'b0;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_ignore got %0d exp 4", q_count); end
    id_feed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (id_ack !== 1'b1 || id_pc !== exp_pc) begin
        errors++; $display("FAIL drain_pc%0d got ack=%b pc=%h exp 1 %h", i, id_ack, id_pc, exp_pc);
      end
      checks++; if (id_k16 !== ~exp_pc || id_iop !== {16'hA5A5, exp_pc}) begin
        errors++; $display("FAIL drain_fields%0d got k16=%h iop=%h exp %h %h", i, id_k16, id_iop, ~exp_pc, {16'hA5A5, exp_pc});
      end
      step();
    end
    id_feed = 1'b0;
    checks++; if (id_ack !== 1'b0 || q_count !== 3'd0) begin
      errors++; $display("FAIL drain_empty got ack=%b cnt=%0d exp 0 0", id_ack, q_count);
    end
  endtask

  task automatic test_full_pop_same_cycle();
    id_feed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(16'h0020 + 16'(i));
      exp_q.push_back(16'h0020 + 16'(i));
      step();
    end
    // Full: pop this cycle must not let the pending push in.
    drive_push(16'h0024);
    id_feed = 1'b1;
    void'(exp_q.pop_front());
    step();
    checks++; if (q_count !== 3'd3 || id_pc !== 16'h0021) begin
      errors++; $display("FAIL fullpop_cnt got cnt=%0d pc=%h exp 3 0021", q_count, id_pc);
    end
    id_feed = 1'b0;
    exp_q.push_back(16'h0024);
    step();
    dec_valid = 1'b0;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL fullpop_late got %0d exp 4", q_count); end
    id_feed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (id_pc !== exp_pc) begin
        errors++; $display("FAIL fullpop_order%0d got %h exp %h", i, id_pc, exp_pc);
      end
      step();
    end
    id_feed = 1'b0;
  endtask

  task automatic test_back_to_back();
    id_feed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_push(16'h0030 + 16'(i));
      exp_q.push_back(16'h0030 + 16'(i));
      step();
    end
    dec_valid = 1'b0;
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL b2b_start got %0d exp 2", q_count); end
    id_feed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (id_ack !== 1'b1 || id_pc !== exp_pc) begin
        errors++; $display("FAIL b2b_pc%0d got ack=%b pc=%h exp 1 %h", i, id_ack, id_pc, exp_pc);
      end
      drive_push(16'h0032 + 16'(i));
      exp_q.push_back(16'h0032 + 16'(i));
      step();
      checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL b2b_cnt%0d got %0d exp 2", i, q_count); end
    end
    dec_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_pc = exp_q.pop_front();
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL b2b_tail%0d got %h exp %h", i, id_pc, exp_pc); end
      step();
    end
    id_feed = 1'b0;
    checks++; if (id_ack !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", id_ack); end
  endtask

  task automatic test_flush();
    id_feed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(16'h0040 + 16'(i));
      step();
    end
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", q_count); end
    drive_push(16'h0043);
    id_feed = 1'b1;
    flush   = 1'b1;
    step();
    flush = 1'b0; dec_valid = 1'b0; id_feed = 1'b0;
    checks++; if (q_count !== 3'd0 || id_ack !== 1'b0 || dec_ready !== 1'b1) begin
      errors++; $display("FAIL flush_post got cnt=%0d ack=%b rdy=%b exp 0 0 1", q_count, id_ack, dec_ready);
    end
    step();
    checks++; if (id_ack !== 1'b0 || id_pc !== 16'h0) begin
      errors++; $display("FAIL flush_drop got ack=%b pc=%h exp 0 0000", id_ack, id_pc);
    end
  endtask

  task automatic test_async_reset();
    id_feed = 1'b0;
    drive_push(16'h0050); step();
    drive_push(16'h0051); step();
    dec_valid = 1'b0;
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL arst_pre got %0d exp 2", q_count); end
    @(negedge clk);
    #2;
    a_rst = 1'b1;
    #1;
    checks++; if (id_ack !== 1'b0 || q_count !== 3'd0 || dec_ready !== 1'b1) begin
      errors++; $display("FAIL arst_async got ack=%b cnt=%0d rdy=%b exp 0 0 1", id_ack, q_count, dec_ready);
    end
    step();
    a_rst = 1'b0;
    drive_push(16'h0060);
    step();
    dec_valid = 1'b0;
    checks++; if (id_ack !== 1'b1 || id_pc !== 16'h0060 || q_count !== 3'd1) begin
      errors++; $display("FAIL arst_push got ack=%b pc=%h cnt=%0d exp 1 0060 1", id_ack, id_pc, q_count);
    end
    id_feed = 1'b1;
    step();
    id_feed = 1'b0;
    checks++; if (id_ack !== 1'b0 || q_count !== 3'd0) begin
      errors++; $display("FAIL arst_pop got ack=%b cnt=%0d exp 0 0", id_ack, q_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_full_drain();
    test_full_pop_same_cycle();
    test_back_to_back();
    test_flush();
    test_async_reset();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
